// File: rtl/ibex_pkg.sv
// Shared constants and types for the data-bus arbiter slice.
package ibex_pkg;

  localparam int unsigned DbusNumHosts = 2;

  typedef enum logic {
    DbusHostCore = 1'b0,
    DbusHostAux  = 1'b1
  } dbus_host_e;

endpackage

// File: rtl/ibex_dbus_id_fifo.sv
// In-order FIFO of 1-bit host IDs for transactions granted downstream but not yet answered.
module ibex_dbus_id_fifo #(
  parameter int unsigned Depth = 2,
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            push_i,
  input  logic            push_data_i,
  input  logic            pop_i,
  output logic            head_o,
  output logic [CntW-1:0] count_o
);

  logic [Depth-1:0] mem_q, mem_d;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  // Pointers wrap explicitly so non-power-of-two depths stay correct.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_i) begin
      mem_d[wr_ptr_q] = push_data_i;
      wr_ptr_d = (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + PtrW'(1);
    end
    if (pop_i) begin
      rd_ptr_d = (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + PtrW'(1);
    end
    case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = cnt_q;

  a_no_overflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push_i && !pop_i && (cnt_q == CntW'(Depth))));

  a_no_underflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(pop_i && (cnt_q == '0)));

endmodule

// File: rtl/ibex_dbus_arbiter.sv
// Two-host round-robin arbiter onto a single data bus with zero-cycle request, grant and response paths.
module ibex_dbus_arbiter
  import ibex_pkg::*;
#(
  parameter int unsigned MemDataWidth   = 32,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [1:0]                   host_req_i,
  output logic [1:0]                   host_gnt_o,
  output logic [1:0]                   host_rvalid_o,
  output logic [1:0]                   host_err_o,
  input  logic [1:0][31:0]             host_addr_i,
  input  logic [1:0]                   host_we_i,
  input  logic [1:0][3:0]              host_be_i,
  input  logic [1:0][MemDataWidth-1:0] host_wdata_i,
  output logic [MemDataWidth-1:0]      host_rdata_o,
  output logic                         data_req_o,
  input  logic                         data_gnt_i,
  input  logic                         data_rvalid_i,
  input  logic                         data_err_i,
  output logic [31:0]                  data_addr_o,
  output logic                         data_we_o,
  output logic [3:0]                   data_be_o,
  output logic [MemDataWidth-1:0]      data_wdata_o,
  input  logic [MemDataWidth-1:0]      data_rdata_i,
  output logic                         busy_o
);

  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

  dbus_host_e      prio_q, prio_d;
  dbus_host_e      lock_id_q, lock_id_d;
  logic            lock_q, lock_d;
  dbus_host_e      winner, sel;
  logic [CntW-1:0] cnt;
  logic            push, pop, head_id, resp_valid;

  // A pending ungranted request pins the winner so the address phase cannot change under it.
  always_comb begin
    winner = DbusHostCore;
    if (lock_q && host_req_i[lock_id_q]) begin
      winner = lock_id_q;
    end else if (&host_req_i) begin
      winner = prio_q;
    end else if (host_req_i[DbusHostAux]) begin
      winner = DbusHostAux;
    end
  end

  assign data_req_o = (|host_req_i) && (cnt < CntW'(MaxOutstanding));
  assign sel        = data_req_o ? winner : DbusHostCore;

  assign data_addr_o  = host_addr_i[sel];
  assign data_we_o    = host_we_i[sel];
  assign data_be_o    = host_be_i[sel];
  assign data_wdata_o = host_wdata_i[sel];

  assign push       = data_req_o && data_gnt_i;
  assign resp_valid = data_rvalid_i && (cnt != '0);
  assign pop        = resp_valid;

  always_comb begin
    host_gnt_o            = '0;
    host_gnt_o[winner]    = push;
    host_rvalid_o         = '0;
    host_rvalid_o[head_id] = resp_valid;
    host_err_o            = '0;
    host_err_o[head_id]   = resp_valid && data_err_i;
  end

  assign host_rdata_o = data_rdata_i;
  assign busy_o       = (cnt != '0);

  always_comb begin
    prio_d    = prio_q;
    lock_d    = data_req_o && !data_gnt_i;
    lock_id_d = lock_d ? winner : lock_id_q;
    if (push) begin
      prio_d = (winner == DbusHostCore) ? DbusHostAux : DbusHostCore;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prio_q    <= DbusHostCore;
      lock_q    <= 1'b0;
      lock_id_q <= DbusHostCore;
    end else begin
      prio_q    <= prio_d;
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
    end
  end

  ibex_dbus_id_fifo #(
    .Depth (MaxOutstanding)
  ) u_id_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (push),
    .push_data_i (winner),
    .pop_i       (pop),
    .head_o      (head_id),
    .count_o     (cnt)
  );

  // A stray response with nothing outstanding is dropped and reported, not treated as fatal.
  a_rvalid_not_empty : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(data_rvalid_i && (cnt == '0)))
    else $warning("data_rvalid_i with no outstanding transaction ignored");

  a_addr_phase_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (data_req_o && !data_gnt_i) |=>
      ($stable(data_addr_o) && $stable(data_we_o) && $stable(data_be_o)));

endmodule

// File: tb/tb_ibex_dbus_arbiter.sv
// Directed self-checking bench for ibex_dbus_arbiter with hand-computed expectations.
module tb_ibex_dbus_arbiter;

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic [1:0]       host_req_i;
  logic [1:0]       host_gnt_o;
  logic [1:0]       host_rvalid_o;
  logic [1:0]       host_err_o;
  logic [1:0][31:0] host_addr_i;
  logic [1:0]       host_we_i;
  logic [1:0][3:0]  host_be_i;
  logic [1:0][31:0] host_wdata_i;
  logic [31:0]      host_rdata_o;
  logic             data_req_o;
  logic             data_gnt_i;
  logic             data_rvalid_i;
  logic             data_err_i;
  logic [31:0]      data_addr_o;
  logic             data_we_o;
  logic [3:0]       data_be_o;
  logic [31:0]      data_wdata_o;
  logic [31:0]      data_rdata_i;
  logic             busy_o;

  int testsRun = 0;
  int testsFailed = 0;

  always #5 clk_i = ~clk_i;

  ibex_dbus_arbiter #(
    .MemDataWidth   (32),
    .MaxOutstanding (2)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .host_req_i    (host_req_i),
    .host_gnt_o    (host_gnt_o),
    .host_rvalid_o (host_rvalid_o),
    .host_err_o    (host_err_o),
    .host_addr_i   (host_addr_i),
    .host_we_i     (host_we_i),
    .host_be_i     (host_be_i),
    .host_wdata_i  (host_wdata_i),
    .host_rdata_o  (host_rdata_o),
    .data_req_o    (data_req_o),
    .data_gnt_i    (data_gnt_i),
    .data_rvalid_i (data_rvalid_i),
    .data_err_i    (data_err_i),
    .data_addr_o   (data_addr_o),
    .data_we_o     (data_we_o),
    .data_be_o     (data_be_o),
    .data_wdata_o  (data_wdata_o),
    .data_rdata_i  (data_rdata_i),
    .busy_o        (busy_o)
  );

  // Drive one cycle's worth of bus-side inputs, then let combinational outputs settle.
  task automatic applyStimulus(input logic [1:0] req, input logic gnt,
                               input logic rvalid, input logic err, input logic [31:0] rdata);
    host_req_i    = req;
    data_gnt_i    = gnt;
    data_rvalid_i = rvalid;
    data_err_i    = err;
    data_rdata_i  = rdata;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    assert (observed === expected)
    else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_ni       = 1'b0;
    host_addr_i  = '{32'h0000_0200, 32'h0000_0100};
    host_we_i    = 2'b10;
    host_be_i    = '{4'b0011, 4'b1111};
    host_wdata_i = '{32'h0000_0022, 32'h0000_0011};
    applyStimulus(2'b00, 1'b0, 1'b0, 1'b0, 32'h0);
    #20;
    checkOutput("reset_gnt", host_gnt_o, 2'b00);
    checkOutput("reset_rvalid", host_rvalid_o, 2'b00);
    checkOutput("reset_req", data_req_o, 1'b0);
    checkOutput("reset_busy", busy_o, 1'b0);
    tick();
    rst_ni = 1'b1;
    tick();
    checkOutput("idle_req", data_req_o, 1'b0);
    checkOutput("idle_addr_host0", data_addr_o, 32'h100);

    // Both hosts request with grant held high: host 0 first, then host 1.
    applyStimulus(2'b11, 1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("rr_gnt0", host_gnt_o, 2'b01);
    checkOutput("rr_addr0", data_addr_o, 32'h100);
    checkOutput("rr_we0", data_we_o, 1'b0);
    tick();
    applyStimulus(2'b10, 1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("rr_gnt1", host_gnt_o, 2'b10);
    checkOutput("rr_addr1", data_addr_o, 32'h200);
    tick();
    applyStimulus(2'b00, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("two_out_busy", busy_o, 1'b1);

    // Responses in order: host 0 with error, host 1 clean.
    applyStimulus(2'b00, 1'b0, 1'b1, 1'b1, 32'hAAAA_0001);
    checkOutput("resp0_rvalid", host_rvalid_o, 2'b01);
    checkOutput("resp0_err", host_err_o, 2'b01);
    checkOutput("resp0_rdata", host_rdata_o, 32'hAAAA_0001);
    tick();
    applyStimulus(2'b00, 1'b0, 1'b1, 1'b0, 32'h5555_0002);
    checkOutput("resp1_rvalid", host_rvalid_o, 2'b10);
    checkOutput("resp1_err", host_err_o, 2'b00);
    tick();
    applyStimulus(2'b00, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("drained_busy", busy_o, 1'b0);

    // Host 1 alone wins although prio points at host 0; it then stays locked while stalled.
    applyStimulus(2'b10, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("lock_c0_addr", data_addr_o, 32'h200);
    checkOutput("lock_c0_gnt", host_gnt_o, 2'b00);
    checkOutput("lock_c0_req", data_req_o, 1'b1);
    tick();
    applyStimulus(2'b11, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("lock_c1_addr", data_addr_o, 32'h200);
    checkOutput("lock_c1_be", data_be_o, 4'b0011);
    tick();
    applyStimulus(2'b11, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("lock_c2_addr", data_addr_o, 32'h200);
    checkOutput("lock_c2_wdata", data_wdata_o, 32'h22);
    checkOutput("lock_c2_we", data_we_o, 1'b1);
    tick();
    applyStimulus(2'b11, 1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("lock_c3_gnt", host_gnt_o, 2'b10);
    checkOutput("lock_c3_addr", data_addr_o, 32'h200);
    tick();
    applyStimulus(2'b01, 1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("after_lock_gnt", host_gnt_o, 2'b01);
    checkOutput("after_lock_addr", data_addr_o, 32'h100);
    tick();
    applyStimulus(2'b00, 1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("lock_resp_h1", host_rvalid_o, 2'b10);
    tick();
    applyStimulus(2'b00, 1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("lock_resp_h0", host_rvalid_o, 2'b01);
    tick();

    // Two grants to host 0 fill the FIFO; a third request stalls until a response frees a slot.
    host_addr_i[0] = 32'h104;
    applyStimulus(2'b01, 1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("fill_gnt_a", host_gnt_o, 2'b01);
    tick();
    host_addr_i[0] = 32'h108;
    applyStimulus(2'b01, 1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("fill_gnt_b", host_gnt_o, 2'b01);
    tick();
    host_addr_i[0] = 32'h10C;
    applyStimulus(2'b01, 1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("full_req", data_req_o, 1'b0);
    checkOutput("full_gnt", host_gnt_o, 2'b00);
    checkOutput("full_busy", busy_o, 1'b1);
    tick();
    applyStimulus(2'b01, 1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("full_pop_req", data_req_o, 1'b0);
    checkOutput("full_pop_gnt", host_gnt_o, 2'b00);
    checkOutput("full_pop_rvalid", host_rvalid_o, 2'b01);
    tick();
    applyStimulus(2'b01, 1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("refill_req", data_req_o, 1'b1);
    checkOutput("refill_gnt", host_gnt_o, 2'b01);
    checkOutput("refill_busy", busy_o, 1'b1);
    tick();
    applyStimulus(2'b01, 1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("refull_req", data_req_o, 1'b0);
    tick();

    // Drain to one outstanding, then reset discards it and a late response is ignored.
    applyStimulus(2'b00, 1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("drain_one_rvalid", host_rvalid_o, 2'b01);
    tick();
    applyStimulus(2'b00, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("one_out_busy", busy_o, 1'b1);
    rst_ni = 1'b0;
    #1;
    checkOutput("midreset_busy", busy_o, 1'b0);
    tick();
    rst_ni = 1'b1;
    tick();
    applyStimulus(2'b00, 1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("late_rvalid", host_rvalid_o, 2'b00);
    checkOutput("late_busy", busy_o, 1'b0);
    checkOutput("late_req", data_req_o, 1'b0);
    tick();
    applyStimulus(2'b00, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
